fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the UART TX async-FIFO write port between N_REQ requesters
//   (e.g. AHB bus writes, loopback/echo path).
//   Grants one requester at a time for a burst of up to MAX_BURST beats.
//   Honours the FIFO full flag and drives the FIFO write-enable/data.
//   Sits on the write-clock side, directly in front of the FIFO write-pointer/Gray-code logic.
// PARAMETERS
//   N_REQ      2   number of requesters (>=2)
//   DATA_W     8   write data width
//   MAX_BURST  4   max beats per grant before forced rotation (>=1; 1 = per-beat round-robin)
// PORTS
//   clk             in   1             write-side clock
//   rst             in   1             reset
//   req_valid_i     in   N_REQ         per-requester data valid
//   req_data_i      in   N_REQ*DATA_W  packed data; requester k at [k*DATA_W +: DATA_W]
//   req_ready_o     out  N_REQ         per-requester accept; beat transfers when valid&ready
//   fifo_full_i     in   1             FIFO full flag (write domain)
//   fifo_wr_en_o    out  1             FIFO write strobe
//   fifo_wr_data_o  out  DATA_W        FIFO write data
//   grant_o         out  N_REQ         one-hot current owner, registered
//   busy_o          out  1             1 while in GRANT state
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset values: state=IDLE, grant_o=0, busy_o=0, beat_cnt=0, rr_ptr=0.
//     req_ready_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0.
//   Reset asserted mid-burst: immediate return to reset values; a beat in that cycle is not written.
//   FSM IDLE:
//     - If any req_valid_i, pick the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//     - Register the one-hot grant, clear beat_cnt, go to GRANT.
//     - Arbitration latency is 1 cycle.
//     - No transfers occur in IDLE.
//   FSM GRANT (owner g):
//     - req_ready_o[g] = !fifo_full_i (combinational); all other readies = 0.
//     - fifo_wr_en_o = req_valid_i[g] & !fifo_full_i.
//     - fifo_wr_data_o = data of g (combinational mux). Outputs 0 when no grant.
//     - Each transfer increments beat_cnt.
//     - A cycle with fifo_full_i=1 is a stall: no write, beat_cnt holds, grant holds (no timeout).
//     - Release to IDLE on either:
//       a) a transfer that makes beat_cnt == MAX_BURST;
//       b) req_valid_i[g]=0 in a cycle with fifo_full_i=0 (early end of burst).
//     - On release, rr_ptr <= (g+1) mod N_REQ, grant_o <= 0.
//     - One bubble (IDLE) cycle always follows a release.
//   Invariants:
//     - grant_o is one-hot or zero.
//     - fifo_wr_en_o is never 1 while fifo_full_i=1.
//     - At most one req_ready_o is high.
//     - beat_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST.
//   Fairness: a continuously-valid requester waits at most (N_REQ-1)*(MAX_BURST+1) transfer/bubble
//     cycles plus stall cycles.
//   Valid de-asserting while full=1 is not a release; it is re-evaluated when full drops.
// TESTING
//   1 Reset: rst=1 mid-burst with full=0 -> same cycle wr_en=0, grant_o=0, ready=0;
//     after release, first grant goes to req0.
//   2 Single requester: req1 valid, 6 beats 0xA0..0xA5, MAX_BURST=4 -> writes A0..A3.
//     Then 1 IDLE cycle, regrant req1, then writes A4,A5.
//   3 Contention: req0 and req1 both valid -> grant pattern 0,0,0,0,bubble,1,1,1,1,bubble,0...
//     FIFO data interleaves in 4-beat groups.
//   4 Full stall: fifo_full_i=1 for 3 cycles after beat 2 -> wr_en=0 and ready=0 for those 3 cycles.
//     beat_cnt stays 2; burst resumes with beats 3,4 and no data loss.
//   5 Early release: req0 valid for 2 beats then low, req1 waiting -> release after beat 2.
//     req1 granted 2 cycles later; rr_ptr=1.
//   6 MAX_BURST=1, N_REQ=3, all valid -> one beat per grant in order 0,1,2,0.
//     Assertion checks: one-hot grant; no write while full.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of the UART TX async-FIFO write port: one owner
// at a time, bursts of up to MAX_BURST beats, and it stalls while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [DATA_W-1:0]       fifo_wr_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [PTR_W-1:0]  owner_idx, pick_idx, next_ptr;
  logic              pick_found, owner_valid, xfer, release_burst;
  logic [DATA_W-1:0] owner_data [N_REQ];

  // Each lane is zeroed unless granted, so the write mux is a plain OR.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign owner_data[gi] = grant_q[gi] ? req_data_i[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    owner_idx      = '0;
    fifo_wr_data_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
      fifo_wr_data_o = fifo_wr_data_o | owner_data[i];
    end
  end

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = (int'(rr_ptr_q) + i) % N_REQ;
      if (!pick_found && req_valid_i[k[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = k[PTR_W-1:0];
      end
    end
  end

  assign owner_valid   = |(req_valid_i & grant_q);
  assign xfer          = (state_q == GRANT) && owner_valid && !fifo_full_i;
  assign release_burst = (state_q == GRANT) && !fifo_full_i &&
                         (!owner_valid || beat_cnt_q == LAST_BEAT);
  assign next_ptr      = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + 1'b1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d           = GRANT;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          beat_cnt_d        = '0;
        end
      end
      GRANT: begin
        busy_o       = 1'b1;
        req_ready_o  = fifo_full_i ? '0 : grant_q;
        fifo_wr_en_o = xfer;
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        // A full FIFO freezes everything; release is judged once full drops.
        if (release_burst) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o = grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model built from the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [N-1:0]    grant;
  logic            busy;

  logic [2:0]  v3, rdy3, g3;
  logic [23:0] d3;
  logic        full3, we3, busy3;
  logic [7:0]  wd3;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .fifo_full_i(fifo_full), .fifo_wr_en_o(wr_en), .fifo_wr_data_o(wr_data),
    .grant_o(grant), .busy_o(busy)
  );

  fifo_wr_arbiter #(.N_REQ(3), .DATA_W(8), .MAX_BURST(1)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid_i(v3), .req_data_i(d3), .req_ready_o(rdy3),
    .fifo_full_i(full3), .fifo_wr_en_o(we3), .fifo_wr_data_o(wd3),
    .grant_o(g3), .busy_o(busy3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state: owner index (-1 = none), beats in burst, round-robin pointer.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;

  int seq[N], base[N], limit[N], start[N];
  int full_lo = 0, full_hi = 0;
  logic [7:0] wq[$];

  task automatic reset_model();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
  endtask

  task automatic set_src(input int k, input int b, input int lim, input int st);
    base[k]  = b;
    limit[k] = lim;
    start[k] = st;
    seq[k]   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    wq.delete();
    full_lo = 0;
    full_hi = 0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic step(input int cyc, input bit rnd);
    logic [N-1:0]  v, exp_g, exp_r;
    logic          f, exp_we;
    logic [DW-1:0] exp_d;
    for (int k = 0; k < N; k++) begin
      if (rnd) v[k] = ($urandom_range(0, 3) != 0);
      else     v[k] = (cyc >= start[k]) && (seq[k] < limit[k]);
      req_data[k*DW +: DW] = DW'(base[k] + seq[k]);
    end
    f = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= full_lo && cyc < full_hi);
    req_valid = v;
    fifo_full = f;
    #2;
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    exp_r  = f ? '0 : exp_g;
    exp_we = (m_owner >= 0) && v[m_owner] && !f;
    exp_d  = (m_owner >= 0) ? DW'(base[m_owner] + seq[m_owner]) : '0;
    check_eq("grant", 32'(grant), 32'(exp_g));
    check_eq("busy", 32'(busy), 32'(m_owner >= 0));
    check_eq("ready", 32'(req_ready), 32'(exp_r));
    check_eq("wr_en", 32'(wr_en), 32'(exp_we));
    check_eq("wr_data", 32'(wr_data), 32'(exp_d));
    check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check_eq("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    check_eq("no_wr_when_full", 32'(wr_en & f), 32'd0);
    if (wr_en) wq.push_back(wr_data);
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++)
        if (m_owner < 0 && v[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_beats = 0;
        end
    end else if (!f) begin
      if (v[m_owner]) begin
        seq[m_owner]++;
        m_beats++;
      end
      if (!v[m_owner] || m_beats == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp3 [8];
    logic [7:0] exp3_d;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    v3        = '0;
    d3        = '0;
    full3     = 1'b0;
    for (int k = 0; k < N; k++) set_src(k, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    reset_model();

    // Reset asserted in the middle of a burst while a beat is in flight.
    set_src(0, 8'h10, 100, 0);
    set_src(1, 8'h20, 100, 0);
    for (int c = 0; c < 3; c++) step(c, 1'b0);
    req_valid = 2'b11;
    fifo_full = 1'b0;
    #2;
    check_eq("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_wr_en", 32'(wr_en), 32'd0);
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    wq.delete();
    step(0, 1'b0);
    check_eq("rst_first_grant", 32'(grant), 32'd1);
    step(1, 1'b0);
    check_eq("rst_resume_cnt", 32'(wq.size()), 32'd1);
    check_eq("rst_resume_data", 32'(wq[0]), 32'h12);

    // Single requester, 6 beats through a 4-beat burst limit.
    do_reset();
    set_src(0, 0, 0, 0);
    set_src(1, 8'hA0, 6, 0);
    for (int c = 0; c < 12; c++) step(c, 1'b0);
    check_eq("single_cnt", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) check_eq("single_data", 32'(wq[i]), 32'(8'hA0 + i));

    // Two-way contention interleaves in 4-beat groups.
    do_reset();
    set_src(0, 8'h00, 12, 0);
    set_src(1, 8'h80, 12, 0);
    for (int c = 0; c < 32; c++) step(c, 1'b0);
    check_eq("contend_cnt", 32'(wq.size()), 32'd24);
    for (int i = 0; i < 24; i++)
      check_eq("contend_data", 32'(wq[i]),
               32'((((i / 4) % 2) != 0 ? 8'h80 : 8'h00) + ((i / 4) / 2) * 4 + i % 4));

    // Full stall for 3 cycles after beat 2.
    do_reset();
    set_src(0, 8'h40, 4, 0);
    set_src(1, 0, 0, 0);
    full_lo = 3;
    full_hi = 6;
    for (int c = 0; c < 12; c++) step(c, 1'b0);
    check_eq("stall_cnt", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("stall_data", 32'(wq[i]), 32'(8'h40 + i));

    // Early release after 2 beats hands over to the waiting requester.
    do_reset();
    set_src(0, 8'h50, 2, 0);
    set_src(1, 8'h60, 3, 1);
    for (int c = 0; c < 10; c++) begin
      step(c, 1'b0);
      if (c == 4) check_eq("early_rel_grant1", 32'(grant), 32'd2);
    end
    check_eq("early_cnt", 32'(wq.size()), 32'd5);
    check_eq("early_last0", 32'(wq[1]), 32'h51);
    check_eq("early_first1", 32'(wq[2]), 32'h60);

    // Random traffic and random full.
    do_reset();
    set_src(0, 8'h00, 0, 0);
    set_src(1, 8'h80, 0, 0);
    for (int c = 0; c < 500; c++) step(c, 1'b1);

    // MAX_BURST=1, three requesters all valid: one beat per grant.
    req_valid = '0;
    fifo_full = 1'b0;
    exp3 = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    v3   = 3'b111;
    d3   = {8'h2C, 8'h1B, 8'h0A};
    for (int c = 0; c < 8; c++) begin
      #2;
      exp3_d = (exp3[c] == 3'b001) ? 8'h0A : (exp3[c] == 3'b010) ? 8'h1B :
               (exp3[c] == 3'b100) ? 8'h2C : 8'h00;
      check_eq("rr1_grant", 32'(g3), 32'(exp3[c]));
      check_eq("rr1_wr_en", 32'(we3), 32'(exp3[c] != 3'b000));
      check_eq("rr1_wr_data", 32'(wd3), 32'(exp3_d));
      check_eq("rr1_ready", 32'(rdy3), 32'(exp3[c]));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
